// File: rtl/hb_mac_sched.sv
// Round-robin scheduler sharing one half-band MAC engine between N_REQ channels.
// One queued job per channel, watchdog on completion, results tagged by channel.
module hb_mac_sched #(
   parameter int N_REQ   = 4,
   parameter int DW_OUT  = 16,
   parameter int TIMEOUT = 255,
   localparam int SW     = $clog2(N_REQ),
   localparam int CW     = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_REQ-1:0]  req,
   input  logic              ovr_clr,
   output logic              mac_start,
   output logic [SW-1:0]     mac_sel,
   input  logic              mac_done,
   input  logic [DW_OUT-1:0] mac_result,
   output logic [N_REQ-1:0]  res_valid,
   output logic [DW_OUT-1:0] res_data,
   output logic [N_REQ-1:0]  overrun,
   output logic              timeout_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   state_t            state, state_nxt;
   logic [N_REQ-1:0]  pend;
   logic [N_REQ-1:0]  grant_oh;
   logic [N_REQ-1:0]  ovr_set;
   logic [SW-1:0]     last;
   logic [SW-1:0]     grant_idx;
   logic [SW-1:0]     cand;
   logic              grant_found;
   logic              grant_en;
   logic              accept;
   logic              expire;
   logic [CW-1:0]     cnt;

   // Search starts one past the last granted channel and wraps.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = SW'((32'(last) + k + 1) % N_REQ);
         if (!grant_found && pend[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      accept    = 1'b0;
      expire    = 1'b0;
      mac_start = 1'b0;
      res_valid = '0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               grant_en  = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            mac_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (mac_done) begin
               accept    = 1'b1;
               state_nxt = DONE;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               expire    = 1'b1;
               state_nxt = IDLE;
            end
         end
         DONE: begin
            res_valid[mac_sel] = 1'b1;
            state_nxt          = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_oh = '0;
      if (grant_en)
         grant_oh[grant_idx] = 1'b1;
   end

   // A request landing on the channel being granted starts a fresh job, not an overrun.
   assign ovr_set = req & pend & ~grant_oh;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend        <= '0;
         overrun     <= '0;
         last        <= SW'(N_REQ - 1);
         mac_sel     <= '0;
         cnt         <= '0;
         res_data    <= '0;
         timeout_err <= 1'b0;
      end else begin
         pend    <= (pend & ~grant_oh) | req;
         overrun <= (ovr_clr ? '0 : overrun) | ovr_set;
         if (grant_en) begin
            last    <= grant_idx;
            mac_sel <= grant_idx;
         end
         if (state == START)
            cnt <= '0;
         else if (state == WAIT)
            cnt <= cnt + CW'(1);
         if (accept)
            res_data <= mac_result;
         if (expire)
            timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hb_mac_sched.sv
// Self-checking bench for hb_mac_sched: vector table, directed corner sequences,
// and randomized traffic against a job-timeline reference model.
module tb_hb_mac_sched;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [N-1:0]  req = '0;
   logic          ovr_clr = 1'b0;
   logic          mac_done = 1'b0;
   logic [DW-1:0] mac_result = '0;
   logic          mac_start;
   logic [1:0]    mac_sel;
   logic [N-1:0]  res_valid;
   logic [DW-1:0] res_data;
   logic [N-1:0]  overrun;
   logic          timeout_err;
   logic          busy;

   always #5 clk = ~clk;

   hb_mac_sched #(.N_REQ(N), .DW_OUT(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .ovr_clr(ovr_clr),
      .mac_start(mac_start), .mac_sel(mac_sel), .mac_done(mac_done),
      .mac_result(mac_result), .res_valid(res_valid), .res_data(res_data),
      .overrun(overrun), .timeout_err(timeout_err), .busy(busy)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cyc = -1;
   int eng_lat = 0;
   bit auto_eng = 1'b0;
   bit rand_mode = 1'b0;
   int grant_q[$];
   int rv_cnt = 0;
   int rv_ok = 0;

   // Model: a job is a timeline of ages (1 = launch, 2..TO+1 = waiting window).
   bit            m_job;
   int            m_ch, m_age, m_res_age, m_sel, m_last;
   logic [N-1:0]  m_pend, m_ovr;
   bit            m_terr;
   logic [DW-1:0] m_rd;

   typedef struct {
      logic [N-1:0]  req;
      logic          done;
      logic [DW-1:0] res;
      logic          est;
      logic [1:0]    esel;
      logic [N-1:0]  erv;
      logic [DW-1:0] erd;
      logic          ebusy;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int gq(input int i);
      return (grant_q.size() > i) ? grant_q[i] : -1;
   endfunction

   function automatic void model_reset();
      m_job = 1'b0; m_ch = 0; m_age = 0; m_res_age = 0; m_sel = 0; m_last = N - 1;
      m_pend = '0; m_ovr = '0; m_terr = 1'b0; m_rd = '0;
   endfunction

   task automatic model_step();
      logic [N-1:0] exp_rv;
      logic [N-1:0] granted;
      int g;
      exp_rv = '0;
      if (m_job && m_res_age != 0 && m_age == m_res_age) exp_rv[m_ch] = 1'b1;
      chk("busy", busy, m_job);
      chk("mac_start", mac_start, m_job && m_age == 1);
      chk("mac_sel", mac_sel, m_sel);
      chk("res_valid", res_valid, exp_rv);
      chk("res_data", res_data, m_rd);
      chk("overrun", overrun, m_ovr);
      chk("timeout_err", timeout_err, m_terr);
      if (mac_start) grant_q.push_back(int'(mac_sel));
      if (res_valid != '0) begin
         rv_cnt++;
         if (res_valid == (4'b0001 << mac_sel)) rv_ok++;
      end
      if (auto_eng && mac_start) begin
         if (rand_mode)        done_cyc = cyc + int'($urandom_range(1, 10));
         else if (eng_lat > 0) done_cyc = cyc + eng_lat;
         else                  done_cyc = -1;
      end
      if (reset) return;
      granted = '0;
      if (m_job) begin
         if (m_res_age != 0) begin
            if (m_age == m_res_age) m_job = 1'b0;
         end else if (m_age >= 2 && mac_done) begin
            m_rd = mac_result;
            m_res_age = m_age + 1;
         end else if (m_age == TO + 1) begin
            m_terr = 1'b1;
            m_job = 1'b0;
         end
         m_age++;
      end else begin
         g = -1;
         for (int k = 1; k <= N; k++)
            if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
         if (g >= 0) begin
            m_job = 1'b1; m_age = 1; m_res_age = 0;
            m_ch = g; m_sel = g; m_last = g; granted[g] = 1'b1;
         end
      end
      if (ovr_clr) m_ovr = '0;
      m_ovr  = m_ovr | (req & m_pend & ~granted);
      m_pend = (m_pend & ~granted) | req;
   endtask

   task automatic tick_a();
      @(negedge clk);
      model_step();
   endtask

   task automatic tick_b();
      @(posedge clk);
      #1;
      cyc++;
      req = '0;
      ovr_clr = 1'b0;
      mac_result = DW'($urandom);
      mac_done = auto_eng && ((cyc == done_cyc) || (rand_mode && $urandom_range(0, 31) == 0));
   endtask

   task automatic tick();
      tick_a();
      tick_b();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      done_cyc = -1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_mac_start", mac_start, 0);
      chk("rst_mac_sel", mac_sel, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout_err", timeout_err, 0);
      model_reset();
      repeat (2) tick();
      reset = 1'b0;
   endtask

   initial begin
      tbl[0] = '{4'b0001, 1'b0, 16'h0000, 1'b0, 2'd0, 4'b0000, 16'h0000, 1'b0};
      tbl[1] = '{4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 4'b0000, 16'h0000, 1'b0};
      tbl[2] = '{4'b0000, 1'b0, 16'h0000, 1'b1, 2'd0, 4'b0000, 16'h0000, 1'b1};
      tbl[3] = '{4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 4'b0000, 16'h0000, 1'b1};
      tbl[4] = '{4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 4'b0000, 16'h0000, 1'b1};
      tbl[5] = '{4'b0000, 1'b1, 16'h1234, 1'b0, 2'd0, 4'b0000, 16'h0000, 1'b1};
      tbl[6] = '{4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 4'b0001, 16'h1234, 1'b1};
      tbl[7] = '{4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 4'b0000, 16'h1234, 1'b0};
      tbl[8] = '{4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 4'b0000, 16'h1234, 1'b0};

      #2;
      do_reset();

      // Single job driven cycle by cycle from the table.
      auto_eng = 1'b0;
      for (int i = 0; i < 9; i++) begin
         req = tbl[i].req;
         mac_done = tbl[i].done;
         if (tbl[i].done) mac_result = tbl[i].res;
         tick_a();
         chk($sformatf("tbl%0d_start", i), mac_start, tbl[i].est);
         chk($sformatf("tbl%0d_sel", i), mac_sel, tbl[i].esel);
         chk($sformatf("tbl%0d_rv", i), res_valid, tbl[i].erv);
         chk($sformatf("tbl%0d_rd", i), res_data, tbl[i].erd);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].ebusy);
         tick_b();
      end

      // All four channels at once.
      do_reset();
      auto_eng = 1'b1; eng_lat = 2;
      grant_q.delete(); rv_cnt = 0; rv_ok = 0;
      req = 4'b1111;
      tick();
      repeat (25) tick();
      chk("sim_grants", grant_q.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("sim_grant%0d", i), gq(i), i);
      chk("sim_rv_count", rv_cnt, 4);
      chk("sim_rv_onehot", rv_ok, 4);

      // Fairness: after channel 1, requests on 0 and 2 go to 2 first.
      req = 4'b0010;
      tick();
      repeat (8) tick();
      grant_q.delete();
      req = 4'b0101;
      tick();
      repeat (15) tick();
      chk("rr_grants", grant_q.size(), 2);
      chk("rr_first", gq(0), 2);
      chk("rr_second", gq(1), 0);

      // Overrun: two requests for channel 0 during its WAIT.
      grant_q.delete();
      eng_lat = 6;
      req = 4'b0001;
      tick(); tick(); tick();
      req = 4'b0001;
      tick();
      req = 4'b0001;
      tick();
      chk("ovr_set", overrun, 4'b0001);
      repeat (30) tick();
      chk("ovr_jobs", grant_q.size(), 2);
      chk("ovr_job0", gq(0), 0);
      chk("ovr_job1", gq(1), 0);
      chk("ovr_sticky", overrun, 4'b0001);
      ovr_clr = 1'b1;
      tick();
      chk("ovr_clr", overrun, 0);

      // Watchdog: engine never answers.
      eng_lat = 0;
      req = 4'b0100;
      tick();
      repeat (9) tick();
      chk("wd_last_wait_busy", busy, 1);
      chk("wd_last_wait_err", timeout_err, 0);
      tick();
      chk("wd_err", timeout_err, 1);
      chk("wd_idle", busy, 0);
      auto_eng = 1'b0;
      mac_done = 1'b1;
      mac_result = 16'hBEEF;
      tick();
      chk("wd_late_done_rv", res_valid, 0);
      chk("wd_late_done_busy", busy, 0);
      chk("wd_late_done_rd", res_data, m_rd);

      // Reset while waiting with channels 1 and 2 queued.
      do_reset();
      auto_eng = 1'b1; eng_lat = 0;
      req = 4'b0001;
      tick(); tick(); tick();
      req = 4'b0110;
      tick();
      tick();
      chk("mid_busy_before", busy, 1);
      do_reset();
      grant_q.delete();
      repeat (6) tick();
      chk("mid_no_jobs", grant_q.size(), 0);
      req = 4'b1100;
      tick();
      repeat (3) tick();
      chk("mid_first_grant", gq(0), 2);

      // Randomized traffic with random latencies, spurious done pulses and clears.
      do_reset();
      auto_eng = 1'b1; rand_mode = 1'b1;
      repeat (3000) begin
         req = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         ovr_clr = ($urandom_range(0, 24) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
